// File: rtl/arb_rr2x1.sv
// Two-requester round-robin arbiter driving a 2:1 mux select; grant/sel registered, 1-cycle latency.
// No backpressure: requesters hold req for a transaction; a waiting peer is rotated in after MAX_HOLD cycles.
module arb_rr2x1 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       sel,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           r_state;
    logic [1:0]       r_grant;
    logic             r_sel;
    logic             r_busy;
    logic             r_preempt;
    logic             r_last_gnt;
    logic [CNT_W-1:0] r_hold_cnt;

    logic w_own_idx;
    logic w_own_req;
    logic w_oth_req;
    logic w_hold_end;
    logic w_idle_pick;

    function automatic state_t gnt_state(input logic idx);
        return idx ? GNT1 : GNT0;
    endfunction

    function automatic logic [1:0] gnt_onehot(input logic idx);
        return {idx, ~idx};
    endfunction

    // Owner/peer view of req so both grant states share one set of rules.
    assign w_own_idx   = (r_state == GNT1);
    assign w_own_req   = req[w_own_idx];
    assign w_oth_req   = req[~w_own_idx];
    assign w_hold_end  = (r_hold_cnt == HOLD_LAST);
    assign w_idle_pick = (req == 2'b11) ? ~r_last_gnt : req[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= 2'b00;
            r_sel      <= 1'b0;
            r_busy     <= 1'b0;
            r_preempt  <= 1'b0;
            r_hold_cnt <= '0;
            r_last_gnt <= 1'b1;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req != 2'b00) begin
                        r_state    <= gnt_state(w_idle_pick);
                        r_grant    <= gnt_onehot(w_idle_pick);
                        r_sel      <= w_idle_pick;
                        r_busy     <= 1'b1;
                        r_last_gnt <= w_idle_pick;
                        r_hold_cnt <= '0;
                    end
                end
                GNT0, GNT1: begin
                    if (!w_own_req && w_oth_req) begin
                        // Voluntary hand-off goes straight across, no idle bubble.
                        r_state    <= gnt_state(~w_own_idx);
                        r_grant    <= gnt_onehot(~w_own_idx);
                        r_sel      <= ~w_own_idx;
                        r_last_gnt <= ~w_own_idx;
                        r_hold_cnt <= '0;
                    end else if (!w_own_req) begin
                        // sel keeps its value so the mux does not toggle while idle.
                        r_state    <= IDLE;
                        r_grant    <= 2'b00;
                        r_busy     <= 1'b0;
                        r_hold_cnt <= '0;
                    end else if (w_hold_end && w_oth_req) begin
                        r_state    <= gnt_state(~w_own_idx);
                        r_grant    <= gnt_onehot(~w_own_idx);
                        r_sel      <= ~w_own_idx;
                        r_last_gnt <= ~w_own_idx;
                        r_hold_cnt <= '0;
                        r_preempt  <= 1'b1;
                    end else if (w_hold_end) begin
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_grant    <= 2'b00;
                    r_busy     <= 1'b0;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    assign grant   = r_grant;
    assign sel     = r_sel;
    assign busy    = r_busy;
    assign preempt = r_preempt;

endmodule

// File: tb/tb_arb_rr2x1.sv
// Scoreboarded bench for arb_rr2x1: directed scenarios plus randomized req traffic against a cycle-count model.
module tb_arb_rr2x1;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] grant;
    logic       sel;
    logic       busy;
    logic       preempt;

    int n_tests = 0;
    int n_fail  = 0;

    arb_rr2x1 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    // Expected {grant, sel, busy, preempt} after each edge.
    logic [4:0] exp_q[$];

    // Reference model: who owns the path and how many cycles it has held it in this window.
    int owner = -1;
    int win   = 0;
    int lastg = 1;
    bit m_sel = 1'b0;
    bit m_pre = 1'b0;

    task automatic model_step(input logic [1:0] r, input logic rs);
        int oth;
        logic [1:0] g;
        m_pre = 1'b0;
        if (rs) begin
            owner = -1; win = 0; lastg = 1; m_sel = 1'b0;
        end else if (owner < 0) begin
            if (r != 2'b00) begin
                if (r == 2'b11) owner = 1 - lastg;
                else            owner = r[1] ? 1 : 0;
                win = 1; lastg = owner;
            end
        end else begin
            oth = 1 - owner;
            if (!r[owner]) begin
                if (r[oth]) begin owner = oth; win = 1; lastg = owner; end
                else begin owner = -1; win = 0; end
            end else if (win == MAX_HOLD) begin
                if (r[oth]) begin owner = oth; lastg = owner; m_pre = 1'b1; end
                win = 1;
            end else begin
                win = win + 1;
            end
        end
        if (owner >= 0) m_sel = (owner == 1);
        g = (owner < 0) ? 2'b00 : ((owner == 1) ? 2'b10 : 2'b01);
        exp_q.push_back({g, m_sel, (owner >= 0), m_pre});
    endtask

    task automatic cycle(input logic [1:0] r, input logic rs);
        @(negedge clk);
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(r, rs);
    endtask

    task automatic dchk(input string name, input logic [4:0] act, input logic [4:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %b required %b ({grant,sel,busy,preempt})", name, act, exp_v);
        end
    endtask

    // Monitor: pops one expectation per edge and checks invariants independently of the stimulus.
    int wait_cnt[2] = '{0, 0};
    initial begin
        logic [4:0] e;
        logic [4:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {grant, sel, busy, preempt};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: got %b required %b ({grant,sel,busy,preempt})", $time, a, e);
                end
                n_tests++;
                if (grant === 2'b11) begin
                    n_fail++;
                    $display("FAIL grant_onehot @%0t: got %b required not 11", $time, grant);
                end
                if (busy === 1'b1) begin
                    n_tests++;
                    if (sel !== grant[1]) begin
                        n_fail++;
                        $display("FAIL sel_match @%0t: sel %b required %b", $time, sel, grant[1]);
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    if (rst || !req[i] || grant[i]) wait_cnt[i] = 0;
                    else wait_cnt[i] = wait_cnt[i] + 1;
                    n_tests++;
                    if (wait_cnt[i] > MAX_HOLD + 1) begin
                        n_fail++;
                        $display("FAIL starvation req%0d @%0t: waited %0d required <= %0d", i, $time, wait_cnt[i], MAX_HOLD + 1);
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0] r;
        logic       rs;

        // Reset state
        cycle(2'b00, 1'b1);
        cycle(2'b00, 1'b1);
        #1 dchk("reset_state", {grant, busy, preempt}, 5'b00000 | {3'b000, 2'b00});

        // Single requester, then release
        cycle(2'b01, 1'b0);
        #1 dchk("t1_grant0", {grant, sel, busy, preempt}, 5'b01010);
        repeat (3) cycle(2'b01, 1'b0);
        cycle(2'b00, 1'b0);
        #1 dchk("t1_release", {grant, sel, busy, preempt}, 5'b00000);

        // Tie after reset goes to requester 0, then direct hand-off
        cycle(2'b00, 1'b1);
        cycle(2'b11, 1'b0);
        #1 dchk("t2_tie", {grant, sel, busy, preempt}, 5'b01010);
        repeat (2) cycle(2'b11, 1'b0);
        cycle(2'b10, 1'b0);
        #1 dchk("t2_handoff", {grant, sel, busy, preempt}, 5'b10110);
        cycle(2'b00, 1'b0);
        #1 dchk("t2_idle_sel", {grant, sel, busy, preempt}, 5'b00100);
        cycle(2'b11, 1'b0);
        #1 dchk("t2_retie", {grant, sel, busy, preempt}, 5'b01010);

        // Forced rotation under constant contention
        cycle(2'b00, 1'b1);
        for (int c = 1; c <= 17; c++) begin
            cycle(2'b11, 1'b0);
            #1;
            if (c == 8)  dchk("t3_c8",  {grant, sel, busy, preempt}, 5'b01010);
            if (c == 9)  dchk("t3_c9",  {grant, sel, busy, preempt}, 5'b10111);
            if (c == 10) dchk("t3_c10", {grant, sel, busy, preempt}, 5'b10110);
            if (c == 17) dchk("t3_c17", {grant, sel, busy, preempt}, 5'b01011);
        end

        // Lone long requester never preempted
        cycle(2'b00, 1'b1);
        for (int c = 1; c <= 30; c++) begin
            cycle(2'b10, 1'b0);
            #1 dchk("t4_lone", {grant, sel, busy, preempt}, 5'b10110);
        end

        // Reset in the middle of a grant
        cycle(2'b00, 1'b1);
        repeat (6) cycle(2'b10, 1'b0);
        cycle(2'b11, 1'b1);
        #1 dchk("t5_rst", {grant, sel, busy, preempt}, 5'b00000);
        cycle(2'b11, 1'b0);
        #1 dchk("t5_after", {grant, sel, busy, preempt}, 5'b01010);

        // Random traffic: sticky requests with occasional drops and rare resets
        r = 2'b00;
        for (int i = 0; i < 10000; i++) begin
            for (int b = 0; b < 2; b++)
                if ($urandom_range(5, 0) == 0) r[b] = ~r[b];
            rs = ($urandom_range(299, 0) == 0);
            cycle(r, rs);
        end

        @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d left required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_rr2x1.md
Name: arb_rr2x1

Overview:
- Two-requester round-robin arbiter that sits directly upstream of the 2:1 select mux in the datapath.
- It decides which of two sources owns the shared path and drives the mux select line.
- It also returns a one-hot grant to the requesters.
- Grants are held for a whole transaction and are forcibly rotated after a bounded hold time, so neither source starves.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one requester keeps the grant while the other waits; legal range 2..2^CNT_W.
- CNT_W, 4: width of the internal hold counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  2  req[n] high = requester n wants the shared path; held high for the whole transaction.
- grant  output  2  one-hot/zero grant, registered; grant[n] high = requester n owns the path.
- sel  output  1  mux select, registered; 0 = input 0, 1 = input 1.
- busy  output  1  high whenever grant != 0.
- preempt  output  1  one-cycle pulse, coincident with the first cycle of a grant taken by forced rotation.

Behaviour:
- Reset:
  - On a clk edge with rst=1: state=IDLE, grant=2'b00, sel=0, busy=0, preempt=0, holdCnt=0, lastGnt=1.
  - With lastGnt=1, requester 0 wins the first tie.
  - Reset mid-transaction drops the grant on that same edge; no partial state survives.
- States: IDLE, GNT0, GNT1. Outputs are decoded from registered state only, so there is no combinational path from req to grant or sel.
- Output mapping:
  - IDLE: grant=00, busy=0, sel holds its last value (avoids mux glitching).
  - GNTn: grant[n]=1, busy=1, sel=n.
- Latency: grant asserts on the first clk edge after req is sampled high (1 cycle).
- IDLE transitions:
  - req=00: stay.
  - req=01: go to GNT0.
  - req=10: go to GNT1.
  - req=11: go to GNT(!lastGnt).
  - Any grant issued from IDLE clears holdCnt to 0 and sets lastGnt=n.
- GNTn transitions (m = other requester), evaluated in priority order:
  1. req[n]=0 and req[m]=1: go directly to GNTm with no idle bubble; holdCnt=0, lastGnt=m, preempt=0.
  2. req[n]=0 and req[m]=0: go to IDLE; holdCnt=0.
  3. req[n]=1 and holdCnt==MAX_HOLD-1 and req[m]=1: forced switch to GNTm; holdCnt=0, lastGnt=m, preempt=1 for that one cycle.
  4. req[n]=1 and holdCnt==MAX_HOLD-1 and req[m]=0: stay in GNTn; holdCnt=0 (hold window restarts, no preempt).
  5. Otherwise: stay; holdCnt increments by 1. It never exceeds MAX_HOLD-1 and never wraps.
- Grant invariants:
  - grant is never 2'b11.
  - A switch between requesters always happens on a single edge: grant goes from 01 to 10 (or 10 to 01) with no 00 cycle and no overlap.
- preempt is 0 in every cycle other than case 3.
- Requester contract: a requester may drop req at any time and the arbiter tolerates it, including while another requester is waiting.

Test Plan:
1. Reset then req=01 at cycle 0:
   - grant=01, sel=0, busy=1 at cycle 1.
   - req=00 at cycle 4 gives grant=00, busy=0 at cycle 5, with sel still 0.
2. Tie from reset: req=11 at cycle 0:
   - grant=01 at cycle 1.
   - Drop req[0] at cycle 3: grant=10, sel=1 at cycle 4, never 00 in between.
   - Drop req[1] and immediately reassert req=11: next grant goes to requester 0.
3. Forced rotation, MAX_HOLD=8: req=11 held constant:
   - grant=01 for cycles 1-8.
   - grant=10 with preempt=1 at cycle 9 only.
   - grant=01 again at cycle 17 with preempt=1.
4. Lone long requester, MAX_HOLD=8: req=10 held 30 cycles:
   - grant=10 continuously.
   - preempt never asserts.
   - holdCnt wraps to 0 every 8 cycles without a grant change.
5. Reset mid-grant: in GNT1 with holdCnt=5, assert rst for one cycle while req=11:
   - Next cycle: grant=00, sel=0, preempt=0.
   - After rst deasserts, grant=01 one cycle later (lastGnt reset to 1).
6. Invariant checks across 10k random req cycles:
   - grant never 11.
   - sel==grant[1] whenever busy=1.
   - No requester waits more than MAX_HOLD+1 cycles while its req is held high.
